// File: rtl/mesh_pkg.sv
// Shared defaults and helpers for the mesh edge bridge.
package mesh_pkg;
  localparam int DEF_N_CH   = 4;
  localparam int DEF_DATA_W = 64;

  // LSB of channel ch inside a flattened N_CH*width vector.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction
endpackage

// File: rtl/mesh_edge_bridge_if.sv
// Host-side and mesh-side handshake bundle for the mesh edge bridge.
interface mesh_edge_bridge_if
  import mesh_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DATA_W = DEF_DATA_W
);
  logic [N_CH-1:0]        inj_valid;
  logic [N_CH*DATA_W-1:0] inj_data;
  logic [N_CH-1:0]        inj_ready;
  logic [N_CH-1:0]        nssi;
  logic [N_CH*DATA_W-1:0] nsdi;
  logic [N_CH-1:0]        nsri;
  logic [N_CH-1:0]        snso;
  logic [N_CH*DATA_W-1:0] sndo;
  logic [N_CH-1:0]        snro;
  logic [N_CH-1:0]        ej_valid;
  logic [N_CH*DATA_W-1:0] ej_data;
  logic [N_CH-1:0]        ej_ready;

  modport slave (
    input  inj_valid, inj_data, nsri, snso, sndo, ej_ready,
    output inj_ready, nssi, nsdi, snro, ej_valid, ej_data
  );

  modport master (
    output inj_valid, inj_data, nsri, snso, sndo, ej_ready,
    input  inj_ready, nssi, nsdi, snro, ej_valid, ej_data
  );
endinterface

// File: rtl/mesh_edge_bridge_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads zero while empty.
module edge_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, used;
  logic              do_push, do_pop;

  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == (AW+1)'(DEPTH));
  assign empty    = (used == '0);
  assign free_cnt = (AW+1)'(DEPTH) - used;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/mesh_edge_bridge.sv
// Per-channel inject/eject buffering between host logic and a mesh row edge.
module mesh_edge_bridge
  import mesh_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         ch_en,
  input  logic                    clr_stats,
  mesh_edge_bridge_if.slave       bus,
  output logic [N_CH*CNT_W-1:0]   tx_cnt,
  output logic [N_CH*CNT_W-1:0]   rx_cnt,
  output logic [N_CH-1:0]         ovf
);
  localparam int FW = $clog2(DEPTH) + 1;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int LSB = ch_lsb(c, DATA_W);

    logic              inj_full, inj_empty, ej_full, ej_empty;
    logic [FW-1:0]     inj_free, ej_free;
    logic [DATA_W-1:0] inj_head, ej_head;
    logic              inj_push, tx_fire, rx_fire, ej_pop;
    logic [CNT_W-1:0]  tx_q, rx_q;
    logic              ovf_q;

    assign inj_push        = bus.inj_valid[c] & ~inj_full;
    assign bus.inj_ready[c] = (inj_free != '0);
    assign bus.nssi[c]     = ch_en[c] & ~inj_empty;
    assign bus.nsdi[LSB +: DATA_W] = inj_head;
    assign tx_fire         = bus.nssi[c] & bus.nsri[c];

    edge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_inj (
      .clk(clk), .reset(reset), .push(inj_push),
      .push_data(bus.inj_data[LSB +: DATA_W]), .pop(tx_fire),
      .head(inj_head), .full(inj_full), .empty(inj_empty), .free_cnt(inj_free)
    );

    // Two free slots: the mesh may already have a word in flight when snro drops.
    assign bus.snro[c]        = ch_en[c] & ~reset & (ej_free >= FW'(2));
    assign rx_fire            = bus.snso[c] & ~ej_full;
    assign bus.ej_valid[c]    = ~ej_empty;
    assign bus.ej_data[LSB +: DATA_W] = ej_head;
    assign ej_pop             = ~ej_empty & bus.ej_ready[c];

    edge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ej (
      .clk(clk), .reset(reset), .push(rx_fire),
      .push_data(bus.sndo[LSB +: DATA_W]), .pop(ej_pop),
      .head(ej_head), .full(ej_full), .empty(ej_empty), .free_cnt(ej_free)
    );

    always_ff @(posedge clk) begin
      if (reset || clr_stats) begin
        tx_q  <= '0;
        rx_q  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (tx_fire) tx_q <= tx_q + 1'b1;
        if (rx_fire) rx_q <= rx_q + 1'b1;
        if (bus.snso[c] && ej_full) ovf_q <= 1'b1;
      end
    end

    assign tx_cnt[c*CNT_W +: CNT_W] = tx_q;
    assign rx_cnt[c*CNT_W +: CNT_W] = rx_q;
    assign ovf[c]                   = ovf_q;
  end
endmodule

// File: tb/tb_mesh_edge_bridge.sv
// Directed bench for mesh_edge_bridge: stepped vector table plus corner-case sequences.
module tb_mesh_edge_bridge;
  localparam int N_CH = 4, DW = 64, DEPTH = 4, CW = 4;

  logic clk = 1'b0, reset, clr_stats;
  logic [N_CH-1:0]      ch_en, ovf;
  logic [N_CH*CW-1:0]   tx_cnt, rx_cnt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mesh_edge_bridge_if #(.N_CH(N_CH), .DATA_W(DW)) bus ();

  mesh_edge_bridge #(.N_CH(N_CH), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .clr_stats(clr_stats),
    .bus(bus), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .ovf(ovf)
  );

  typedef struct {
    logic en, iv; logic [63:0] id; logic nsri, snso; logic [63:0] sndo; logic ejr;
    logic e_nssi; logic [63:0] e_nsdi; logic e_rdy, e_snro, e_ejv; logic [63:0] e_ejd;
    logic [3:0] e_tx, e_rx;
  } vec_t;
  vec_t tv [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] nsdi_c(input int c);  return bus.nsdi[c*DW +: DW];    endfunction
  function automatic logic [63:0] ejd_c(input int c);   return bus.ej_data[c*DW +: DW]; endfunction
  function automatic logic [63:0] tx_c(input int c);    return 64'(tx_cnt[c*CW +: CW]); endfunction
  function automatic logic [63:0] rx_c(input int c);    return 64'(rx_cnt[c*CW +: CW]); endfunction

  task automatic pulse_clr();
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
  endtask

  initial begin
    logic s;
    int sent, fell_at;

    tv[0] = '{1,1,64'hA1,0,0,64'h0 ,0,  1,64'hA1,1,1,0,64'h0 , 4'd0,4'd0};
    tv[1] = '{1,1,64'hA2,1,0,64'h0 ,0,  1,64'hA2,1,1,0,64'h0 , 4'd1,4'd0};
    tv[2] = '{1,0,64'h0 ,1,1,64'hB1,0,  0,64'h0 ,1,1,1,64'hB1, 4'd2,4'd1};
    tv[3] = '{1,0,64'h0 ,1,1,64'hB2,1,  0,64'h0 ,1,1,1,64'hB2, 4'd2,4'd2};
    tv[4] = '{0,1,64'hA3,1,0,64'h0 ,0,  0,64'hA3,1,0,1,64'hB2, 4'd2,4'd2};
    tv[5] = '{1,0,64'h0 ,1,0,64'h0 ,0,  0,64'h0 ,1,1,1,64'hB2, 4'd3,4'd2};
    tv[6] = '{1,0,64'h0 ,0,0,64'h0 ,1,  0,64'h0 ,1,1,0,64'h0 , 4'd3,4'd2};

    reset = 1'b1; clr_stats = 1'b0; ch_en = '1;
    bus.inj_valid = '0; bus.inj_data = '0; bus.nsri = '0;
    bus.snso = '0; bus.sndo = '0; bus.ej_ready = '0;

    // Reset held with the mesh strobing: nothing may be captured.
    for (int i = 0; i < 5; i++) begin
      bus.snso = ~bus.snso;
      bus.sndo = {N_CH{64'h5A5A_0000_0000_0000 + 64'(i)}};
      step();
    end
    chk("rst nssi",      64'(bus.nssi),      64'h0);
    chk("rst ej_valid",  64'(bus.ej_valid),  64'h0);
    chk("rst ovf",       64'(ovf),           64'h0);
    chk("rst tx_cnt",    64'(tx_cnt),        64'h0);
    chk("rst rx_cnt",    64'(rx_cnt),        64'h0);
    chk("rst inj_ready", 64'(bus.inj_ready), 64'hF);
    chk("rst snro",      64'(bus.snro),      64'h0);
    chk("rst nsdi0",     nsdi_c(0),          64'h0);
    chk("rst ej_data0",  ejd_c(0),           64'h0);
    reset = 1'b0; bus.snso = '0; bus.sndo = '0;
    step();
    chk("post-rst snro",     64'(bus.snro),     64'hF);
    chk("post-rst ej_valid", 64'(bus.ej_valid), 64'h0);
    chk("post-rst rx_cnt",   64'(rx_cnt),       64'h0);

    for (int i = 0; i < 7; i++) begin
      ch_en[0] = tv[i].en; bus.inj_valid[0] = tv[i].iv; bus.inj_data[0 +: DW] = tv[i].id;
      bus.nsri[0] = tv[i].nsri; bus.snso[0] = tv[i].snso; bus.sndo[0 +: DW] = tv[i].sndo;
      bus.ej_ready[0] = tv[i].ejr;
      step();
      chk($sformatf("v%0d nssi", i),      64'(bus.nssi[0]),      64'(tv[i].e_nssi));
      chk($sformatf("v%0d nsdi", i),      nsdi_c(0),             tv[i].e_nsdi);
      chk($sformatf("v%0d inj_ready", i), 64'(bus.inj_ready[0]), 64'(tv[i].e_rdy));
      chk($sformatf("v%0d snro", i),      64'(bus.snro[0]),      64'(tv[i].e_snro));
      chk($sformatf("v%0d ej_valid", i),  64'(bus.ej_valid[0]),  64'(tv[i].e_ejv));
      chk($sformatf("v%0d ej_data", i),   ejd_c(0),              tv[i].e_ejd);
      chk($sformatf("v%0d tx_cnt", i),    tx_c(0),               64'(tv[i].e_tx));
      chk($sformatf("v%0d rx_cnt", i),    rx_c(0),               64'(tv[i].e_rx));
    end
    bus.inj_valid = '0; bus.nsri = '0; bus.snso = '0; bus.ej_ready = '0; ch_en = '1;
    pulse_clr();

    // Inject stream on channel 2.
    bus.nsri[2] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.inj_valid[2] = 1'b1;
      bus.inj_data[2*DW +: DW] = {16{4'(i)}};
      step();
      chk($sformatf("stream nsdi w%0d", i), nsdi_c(2), {16{4'(i)}});
    end
    bus.inj_valid[2] = 1'b0;
    step();
    chk("stream nssi empty", 64'(bus.nssi[2]), 64'h0);
    chk("stream tx_cnt2",    tx_c(2),          64'd3);
    chk("stream idle tx",    tx_c(0) | tx_c(1) | tx_c(3), 64'h0);
    chk("stream idle nssi",  64'(bus.nssi & 4'b1011),     64'h0);
    bus.nsri[2] = 1'b0;

    // Inject stall on channel 1: fifth push must be refused.
    for (int i = 0; i < 5; i++) begin
      bus.inj_valid[1] = 1'b1;
      bus.inj_data[1*DW +: DW] = 64'hD1 + 64'(i);
      step();
      chk($sformatf("stall ready after push %0d", i+1), 64'(bus.inj_ready[1]), 64'(i < 3));
    end
    bus.inj_valid[1] = 1'b0;
    bus.nsri[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain nsdi w%0d", i+1), nsdi_c(1), 64'hD1 + 64'(i));
      step();
    end
    chk("drain nssi empty", 64'(bus.nssi[1]), 64'h0);
    chk("drain tx_cnt1",    tx_c(1),          64'd4);
    bus.nsri[1] = 1'b0;

    // Eject back-pressure on channel 3: mesh strobes one cycle after seeing snro.
    sent = 0; fell_at = -1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      s = bus.snro[3];
      if (!s && fell_at < 0) fell_at = int'(rx_c(3));
      step();
      bus.snso[3] = s;
      bus.sndo[3*DW +: DW] = 64'hC1 + 64'(sent);
      if (s) sent++;
    end
    bus.snso[3] = 1'b0;
    chk("bp stored at snro fall", 64'(fell_at), 64'd3);
    chk("bp rx_cnt3",   rx_c(3),              64'd4);
    chk("bp strobes",   64'(sent),            64'd4);
    chk("bp ovf3",      64'(ovf[3]),          64'h0);
    chk("bp ej_valid3", 64'(bus.ej_valid[3]), 64'h1);

    // Overflow: strobe into the full FIFO.
    bus.snso[3] = 1'b1; bus.sndo[3*DW +: DW] = 64'hDEAD;
    step();
    bus.snso[3] = 1'b0;
    chk("ovf set",       64'(ovf[3]), 64'h1);
    chk("ovf rx_cnt3",   rx_c(3),     64'd4);
    bus.ej_ready[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ej pop w%0d", i+1), ejd_c(3), 64'hC1 + 64'(i));
      step();
    end
    bus.ej_ready[3] = 1'b0;
    chk("ej drained", 64'(bus.ej_valid[3]), 64'h0);
    chk("ovf sticky", 64'(ovf[3]),          64'h1);
    pulse_clr();
    step();
    chk("clr ovf",     64'(ovf[3]), 64'h0);
    chk("clr rx_cnt3", rx_c(3),     64'd0);

    // Counter wrap at CNT_W=4, then a transfer coinciding with clr_stats.
    bus.nsri[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.inj_valid[0] = 1'b1;
      bus.inj_data[0 +: DW] = 64'(i);
      step();
    end
    bus.inj_valid[0] = 1'b0;
    step();
    chk("wrap tx_cnt0", tx_c(0), 64'd1);
    bus.inj_valid[0] = 1'b1;
    step();
    bus.inj_valid[0] = 1'b0;
    chk("pre-clr tx_cnt0", tx_c(0), 64'd1);
    chk("pre-clr nssi0",   64'(bus.nssi[0]), 64'h1);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr wins tx_cnt0", tx_c(0), 64'd0);
    chk("clr popped nssi0", 64'(bus.nssi[0]), 64'h0);
    bus.nsri[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mesh_edge_bridge.md
# mesh_edge_bridge

Parametrised edge-port bridge between test or host logic and the N edge channels of a mesh row. Each channel has two directions:
- **Inject:** words from the host side are buffered and presented to the mesh on the nssi/nsdi/nsri handshake.
- **Eject:** words leaving the mesh on snso/sndo are captured into a FIFO, gated by snro back-pressure, and handed to the host side.

It replaces the hand-driven per-node stimulus registers around `mesh_row_0`. It adds channel count, data width and depth parameters, per-channel enable, traffic counters and sticky overflow flags.

## Interface
Parameters:
- `N_CH`, 4: number of edge channels.
- `DATA_W`, 64: word width.
- `DEPTH`, 4: per-direction FIFO depth. Must be a power of two, ≥ 2.
- `CNT_W`, 16: width of the traffic counters.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `ch_en`  in  N_CH  per-channel enable for the mesh-side handshake
- `clr_stats`  in  1  synchronous clear of counters and overflow flags
- `inj_valid`  in  N_CH  host word available
- `inj_data`  in  N_CH*DATA_W  host word; channel c occupies bits [c*DATA_W +: DATA_W]
- `inj_ready`  out  N_CH  inject FIFO not full
- `nssi`  out  N_CH  send strobe into mesh
- `nsdi`  out  N_CH*DATA_W  data into mesh
- `nsri`  in  N_CH  mesh ready to accept
- `snso`  in  N_CH  mesh send strobe out
- `sndo`  in  N_CH*DATA_W  data out of mesh
- `snro`  out  N_CH  bridge ready to receive
- `ej_valid`  out  N_CH  eject FIFO not empty
- `ej_data`  out  N_CH*DATA_W  eject FIFO head
- `ej_ready`  in  N_CH  host pops the head
- `tx_cnt`  out  N_CH*CNT_W  words accepted by the mesh
- `rx_cnt`  out  N_CH*CNT_W  words captured from the mesh
- `ovf`  out  N_CH  sticky flag: a mesh word was dropped

## Operation
- Channels are fully independent. There is no arbitration between channels.

Inject:
- Host push occurs when `inj_valid & inj_ready`.
- `nssi[c] = ch_en[c] & !inj_empty[c]`; `nsdi[c]` = inject FIFO head.
- Mesh transfer occurs when `nssi & nsri` at the clock edge. That edge pops the FIFO and increments `tx_cnt`.
- `nssi` has no combinational dependence on `nsri`.

Eject:
- `snro[c] = ch_en[c] & (free_slots >= 2)`. The mesh may strobe one cycle after sampling `snro`, so the extra slot absorbs that in-flight word.
- Any cycle with `snso=1`: if the FIFO is not full, push `sndo` and increment `rx_cnt`. If it is full, drop the word and set `ovf`.
- `snso` is honoured regardless of `ch_en`.
- Host pop occurs when `ej_valid & ej_ready`.

FIFO behaviour:
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- An empty FIFO does not bypass: a pushed word becomes visible the next cycle.
- Pointers wrap modulo `DEPTH`.

Counters and flags:
- Counters wrap modulo 2^CNT_W.
- `clr_stats` zeroes all counters and `ovf`. If an event coincides with `clr_stats`, the clear wins and the counter reads 0.
- Deasserting `ch_en` freezes the mesh-side handshake only. FIFO contents are retained.

## Timing
- Reset state:
  - All FIFOs empty; `nssi`, `ej_valid`, `ovf`, `tx_cnt`, `rx_cnt` all 0.
  - `inj_ready` = 1 and `nsdi`/`ej_data` = 0 during reset.
  - `snro` is 0 while `reset` is high, then `ch_en`-gated 1 on the first cycle after.
- Inject latency: a host push at edge k gives `nssi` = 1 from edge k onward. With `nsri` = 1 the word is consumed at edge k+1.
- Throughput is one word per cycle per channel in each direction. A sustained stream keeps `snro` = 1 while free slots ≥ 2.
- Eject latency: a capture at edge k gives `ej_valid` = 1 after edge k.
- `reset` asserted mid-transfer discards all buffered words. It takes priority over `clr_stats` and all handshakes.

## Structure
- Package `mesh_pkg`:
  - default `DATA_W`/`N_CH` constants
  - channel-slice index helper
- One sub-module, `edge_fifo` (parameters `DATA_W`, `DEPTH`):
  - synchronous, registered pointers with wrap bit
  - outputs `full`, `empty`, `free_cnt`
  - instantiated 2×N_CH via generate.
- Counters and the `ovf` logic live in the top-level generate loop.

## Test plan
- **Reset:** hold `reset` 5 cycles with `snso` toggling → all outputs at reset values, no counts; `snro` = 1 the cycle after release.
- **Inject stream:** push 0x1111…, 0x2222…, 0x3333… on channel 2 with `nsri` = 1 → `nsdi` presents them in order on consecutive cycles; `tx_cnt[2]` = 3; other channels idle.
- **Inject stall:** `nsri` = 0 with 5 pushes, DEPTH = 4 → `inj_ready` drops after the 4th push; raising `nsri` drains all 4 in order.
- **Eject back-pressure:** `ej_ready` = 0 while the mesh strobes whenever `snro` is high → `snro` falls when 3 words are stored; exactly 4 are captured, `ovf` = 0.
- **Overflow:** force `snso` on a full eject FIFO → word dropped, `ovf` = 1, `rx_cnt` unchanged; `clr_stats` → `ovf` = 0.
- **Counter wrap, CNT_W = 4:** 17 transfers → `tx_cnt` = 1; `clr_stats` coincident with a transfer → `tx_cnt` = 0.
